matrix_result_collector: RTL and testbench

- Receiving end of the systolic_matrix_mult C-output stream (c_data/c_row/c_col/c_valid/done).
- Captures out-of-order, element-addressed results into an MxN buffer and tracks which entries have arrived.
- Once done is seen, re-emits the matrix in strict row-major order on a valid/ready stream for downstream blocks (softmax, next matmul loader).
- Flags duplicate, out-of-range, late and missing elements.

---
 rtl/matrix_result_collector_pkg.sv | 19 +
 rtl/matrix_result_collector_rowmajor_index_counter.sv | 42 ++++
 rtl/matrix_result_collector.sv | 184 ++++++++++++++++++
 tb/tb_matrix_result_collector.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_result_collector_pkg.sv
// Shared types and helpers for the matrix result collector
// and the row-major loaders built around the systolic array.
package matrix_result_collector_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int FRAC_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Index width that never collapses to zero for a 1-deep dimension
    function automatic int idx_w(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

endpackage

// File: rtl/matrix_result_collector_rowmajor_index_counter.sv
// Row-major (row, col) walker over a ROWS x COLS grid.
// clr has priority over inc; the walk wraps to (0,0) after the last cell.
module rowmajor_index_counter
    import matrix_result_collector_pkg::*;
#(
    parameter int ROWS = 5,
    parameter int COLS = 5,
    localparam int ROW_W = idx_w(ROWS),
    localparam int COL_W = idx_w(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    logic row_end;
    logic col_end;

    assign row_end = (int'(row) == ROWS - 1);
    assign col_end = (int'(col) == COLS - 1);
    assign last    = row_end && col_end;

    // Advance column first, carrying into the row at the end of a line
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_result_collector.sv
// Collects element-addressed matmul results in any order, then
// replays the full matrix row-major on a valid/ready stream.
module matrix_result_collector
    import matrix_result_collector_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
    parameter int M = 5,
    parameter int N = 5,
    localparam int ROW_W = idx_w(M),
    localparam int COL_W = idx_w(N),
    localparam int CNT_W = $clog2(M * N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] c_data,
    input  logic [ROW_W-1:0]      c_row,
    input  logic [COL_W-1:0]      c_col,
    input  logic                  c_valid,
    input  logic                  done,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ROW_W-1:0]      out_row,
    output logic [COL_W-1:0]      out_col,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [CNT_W-1:0]      elem_count,
    output logic                  dup_err,
    output logic                  range_err,
    output logic                  late_err,
    output logic                  missing_err,
    output logic                  drain_done
);

    localparam int DEPTH = M * N;
    localparam int IDX_W = idx_w(DEPTH);

    // Q-format is only carried through; it must still fit the word
    if (FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_frac
        $error("FRAC_WIDTH must be smaller than DATA_WIDTH");
    end

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0] buffer [DEPTH];
    logic [DEPTH-1:0]      bitmap;

    logic             collect;
    logic             draining;
    logic             in_range;
    logic             wr_en;
    logic             is_dup;
    logic             hs;
    logic             finish;
    logic             cnt_clr;
    logic             cnt_last;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] cnt_nxt;
    logic [ROW_W-1:0] cnt_row;
    logic [COL_W-1:0] cnt_col;

    assign collect  = (state == COLLECT);
    assign draining = (state == DRAIN);
    assign hs       = out_valid && out_ready;
    assign finish   = draining && hs && cnt_last;

    assign in_range = (int'(c_row) < M) && (int'(c_col) < N);
    assign wr_idx   = IDX_W'(int'(c_row) * N + int'(c_col));
    assign rd_idx   = IDX_W'(int'(cnt_row) * N + int'(cnt_col));
    assign wr_en    = collect && c_valid && in_range && !start;
    assign is_dup   = in_range && bitmap[wr_idx];
    assign cnt_nxt  = (wr_en && !is_dup) ? elem_count + CNT_W'(1)
                                         : elem_count;
    assign cnt_clr  = start || (collect && done);

    rowmajor_index_counter #(
        .ROWS (M),
        .COLS (N)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (hs),
        .row  (cnt_row),
        .col  (cnt_col),
        .last (cnt_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start restarts from anywhere, done ends collection
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (start)     state_nxt = COLLECT;
                else if (done) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (start)       state_nxt = COLLECT;
                else if (finish) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; absent entries read as zero via the bitmap
    always_comb begin
        busy     = (state != IDLE);
        out_last = out_valid && cnt_last;
        out_row  = out_valid ? cnt_row : '0;
        out_col  = out_valid ? cnt_col : '0;
        out_data = '0;
        if (out_valid && bitmap[rd_idx]) begin
            out_data = buffer[rd_idx];
        end
    end

    // Element storage; contents are qualified by the bitmap, not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[wr_idx] <= c_data;
        end
    end

    // Arrival tracking, sticky error flags and stream valid
    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap      <= '0;
            elem_count  <= '0;
            dup_err     <= 1'b0;
            range_err   <= 1'b0;
            late_err    <= 1'b0;
            missing_err <= 1'b0;
            out_valid   <= 1'b0;
            drain_done  <= 1'b0;
        end else if (start) begin
            bitmap      <= '0;
            elem_count  <= '0;
            dup_err     <= 1'b0;
            range_err   <= 1'b0;
            late_err    <= 1'b0;
            missing_err <= 1'b0;
            out_valid   <= 1'b0;
            drain_done  <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            elem_count <= cnt_nxt;
            if (wr_en) begin
                bitmap[wr_idx] <= 1'b1;
                if (is_dup) dup_err <= 1'b1;
            end
            if (collect && c_valid && !in_range) begin
                range_err <= 1'b1;
            end
            if (!collect && c_valid) begin
                late_err <= 1'b1;
            end
            if (collect && done) begin
                out_valid <= 1'b1;
                if (int'(cnt_nxt) < DEPTH) missing_err <= 1'b1;
            end
            if (finish) begin
                out_valid  <= 1'b0;
                drain_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_result_collector.sv
// Directed bench for matrix_result_collector: scenario table plus
// a hand-written reset-during-drain sequence.
module tb_matrix_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] c_data;
    logic [2:0]  c_row;
    logic [2:0]  c_col;
    logic        c_valid;
    logic        done;
    logic [15:0] out_data;
    logic [2:0]  out_row;
    logic [2:0]  out_col;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [4:0]  elem_count;
    logic        dup_err;
    logic        range_err;
    logic        late_err;
    logic        missing_err;
    logic        drain_done;

    int n_tests = 0;
    int n_fail  = 0;

    matrix_result_collector dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .c_data      (c_data),
        .c_row       (c_row),
        .c_col       (c_col),
        .c_valid     (c_valid),
        .done        (done),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .elem_count  (elem_count),
        .dup_err     (dup_err),
        .range_err   (range_err),
        .late_err    (late_err),
        .missing_err (missing_err),
        .drain_done  (drain_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit reverse;
        bit done_with_last;
        bit stall;
        bit dup;
        bit bad_row;
        bit late;
        bit skip;
        bit exp_missing;
        bit exp_dup;
        bit exp_range;
        bit exp_late;
        int exp_count;
    } scen_t;

    scen_t tbl[5];
    bit    rdy_pat[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
        end
    endtask

    function automatic logic [15:0] elem_val(input int s, input int r,
                                             input int c);
        if (tbl[s].dup && r == 1 && c == 1) return 16'h0600;
        return 16'((5 * r + c + 1) * 256);
    endfunction

    function automatic logic [15:0] exp_val(input int s, input int r,
                                            input int c);
        if (tbl[s].skip && r == 2 && c == 3) return 16'h0000;
        return elem_val(s, r, c);
    endfunction

    task automatic collect_phase(input int s);
        int p;
        int r;
        int c;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("s%0d busy after start", s), busy, 1);
        chk($sformatf("s%0d count after start", s), elem_count, 0);
        if (tbl[s].bad_row) begin
            c_valid = 1'b1;
            c_row   = 3'd5;
            c_col   = 3'd0;
            c_data  = 16'hDEAD;
            tick();
        end
        if (tbl[s].dup) begin
            c_valid = 1'b1;
            c_row   = 3'd1;
            c_col   = 3'd1;
            c_data  = 16'h0300;
            tick();
        end
        for (int n = 0; n < 25; n++) begin
            p = tbl[s].reverse ? 24 - n : n;
            r = p / 5;
            c = p % 5;
            if (tbl[s].skip && r == 2 && c == 3) continue;
            c_valid = 1'b1;
            c_row   = 3'(r);
            c_col   = 3'(c);
            c_data  = elem_val(s, r, c);
            done    = tbl[s].done_with_last && (n == 24);
            tick();
        end
        c_valid = 1'b0;
        if (!tbl[s].done_with_last) begin
            done = 1'b1;
            tick();
        end
        done = 1'b0;
        chk($sformatf("s%0d out_valid 1 cycle after done", s), out_valid, 1);
        chk($sformatf("s%0d elem_count at done", s), elem_count,
            tbl[s].exp_count);
        chk($sformatf("s%0d missing_err at done", s), missing_err,
            tbl[s].exp_missing);
    endtask

    task automatic drain_phase(input int s, input int target);
        int          k;
        int          cyc;
        bit          held;
        logic [15:0] pd;
        logic [2:0]  pr;
        logic [2:0]  pc;
        logic        pl;
        k    = 0;
        cyc  = 0;
        held = 1'b0;
        while (k < target && cyc < 400) begin
            out_ready = tbl[s].stall ? rdy_pat[cyc % 4] : 1'b1;
            if (tbl[s].late) begin
                c_valid = (cyc == 0);
                c_row   = 3'd4;
                c_col   = 3'd4;
                c_data  = 16'hBEEF;
            end
            chk($sformatf("s%0d valid during drain c%0d", s, cyc),
                out_valid, 1);
            if (held) begin
                chk($sformatf("s%0d stall data k%0d", s, k), out_data, pd);
                chk($sformatf("s%0d stall row k%0d", s, k), out_row, pr);
                chk($sformatf("s%0d stall col k%0d", s, k), out_col, pc);
                chk($sformatf("s%0d stall last k%0d", s, k), out_last, pl);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("s%0d out_data k%0d", s, k), out_data,
                    exp_val(s, k / 5, k % 5));
                chk($sformatf("s%0d out_row k%0d", s, k), out_row, k / 5);
                chk($sformatf("s%0d out_col k%0d", s, k), out_col, k % 5);
                chk($sformatf("s%0d out_last k%0d", s, k), out_last,
                    (k == 24));
                k++;
            end
            held = out_valid && !out_ready;
            pd   = out_data;
            pr   = out_row;
            pc   = out_col;
            pl   = out_last;
            tick();
            cyc++;
        end
        c_valid = 1'b0;
        if (k < target) begin
            chk($sformatf("s%0d drain timeout handshakes", s), k, target);
        end
        if (!tbl[s].stall && target == 25) begin
            chk($sformatf("s%0d cycles for 25 outputs", s), cyc, 25);
        end
    endtask

    task automatic end_checks(input int s);
        out_ready = 1'b0;
        chk($sformatf("s%0d drain_done pulse", s), drain_done, 1);
        chk($sformatf("s%0d out_valid after last", s), out_valid, 0);
        chk($sformatf("s%0d busy after last", s), busy, 0);
        chk($sformatf("s%0d dup_err", s), dup_err, tbl[s].exp_dup);
        chk($sformatf("s%0d range_err", s), range_err, tbl[s].exp_range);
        chk($sformatf("s%0d late_err", s), late_err, tbl[s].exp_late);
        chk($sformatf("s%0d missing_err end", s), missing_err,
            tbl[s].exp_missing);
        chk($sformatf("s%0d elem_count end", s), elem_count,
            tbl[s].exp_count);
        tick();
        chk($sformatf("s%0d drain_done one cycle", s), drain_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{reverse:0, done_with_last:0, stall:0, dup:0, bad_row:0,
                   late:0, skip:0, exp_missing:0, exp_dup:0, exp_range:0,
                   exp_late:0, exp_count:25};
        tbl[1] = '{reverse:1, done_with_last:1, stall:0, dup:0, bad_row:0,
                   late:0, skip:0, exp_missing:0, exp_dup:0, exp_range:0,
                   exp_late:0, exp_count:25};
        tbl[2] = '{reverse:0, done_with_last:0, stall:1, dup:0, bad_row:0,
                   late:0, skip:0, exp_missing:0, exp_dup:0, exp_range:0,
                   exp_late:0, exp_count:25};
        tbl[3] = '{reverse:0, done_with_last:0, stall:0, dup:0, bad_row:0,
                   late:0, skip:1, exp_missing:1, exp_dup:0, exp_range:0,
                   exp_late:0, exp_count:24};
        tbl[4] = '{reverse:0, done_with_last:0, stall:0, dup:1, bad_row:1,
                   late:1, skip:0, exp_missing:0, exp_dup:1, exp_range:1,
                   exp_late:1, exp_count:25};
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst       = 1'b1;
        start     = 1'b0;
        c_data    = '0;
        c_row     = '0;
        c_col     = '0;
        c_valid   = 1'b0;
        done      = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset elem_count", elem_count, 0);
        chk("reset flags", {dup_err, range_err, late_err, missing_err}, 0);
        chk("reset out_last", out_last, 0);
        chk("reset out_data", out_data, 0);
        chk("reset drain_done", drain_done, 0);

        done = 1'b1;
        tick();
        done = 1'b0;
        chk("done in IDLE busy", busy, 0);
        chk("done in IDLE out_valid", out_valid, 0);

        for (int s = 0; s < 5; s++) begin
            collect_phase(s);
            drain_phase(s, 25);
            end_checks(s);
        end

        collect_phase(0);
        drain_phase(0, 10);
        rst = 1'b1;
        tick();
        chk("mid-drain rst out_valid", out_valid, 0);
        chk("mid-drain rst busy", busy, 0);
        chk("mid-drain rst flags",
            {dup_err, range_err, late_err, missing_err}, 0);
        chk("mid-drain rst elem_count", elem_count, 0);
        chk("mid-drain rst drain_done", drain_done, 0);
        rst = 1'b0;
        tick();
        chk("post rst out_valid", out_valid, 0);
        collect_phase(0);
        drain_phase(0, 25);
        end_checks(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
